seq110_word_scheduler: RTL and testbench

Controller that feeds parallel words, one bit per cycle MSB-first, into a single 110-pattern detection engine. It counts and locates every "110" match in each word and returns the result through a valid/ready handshake. It sits between an upstream word source and downstream match-statistics logic. It owns sequencing, clearing and history control of the detection engine.

---
 rtl/seq110_pkg.sv | 14 +
 rtl/seq110_core.sv | 37 +++
 rtl/seq110_word_scheduler.sv | 132 +++++++++++++
 tb/tb_seq110_word_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq110_pkg.sv
// Shared types for the 110-pattern word scheduler: FSM state encoding and
// the bit pattern the detection engine looks for.
package seq110_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Oldest bit first: a match is 1, then 1, then 0.
  localparam logic [2:0] PATTERN = 3'b110;

endpackage

// File: rtl/seq110_core.sv
// Single-bit 110 detection engine. Keeps the last two presented bits; hit
// fires combinationally when the current bit completes the pattern.
module seq110_core
  import seq110_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  logic [1:0] hist_q, hist_d;

  // History update: clear wins over a presented bit.
  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (bit_en) begin
      hist_d = {hist_q[0], bit_in};
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hit = bit_en && (hist_q == PATTERN[2:1]) && (bit_in == PATTERN[0]);

endmodule

// File: rtl/seq110_word_scheduler.sv
// Serializes each accepted word MSB-first into seq110_core, records the count
// and bit positions of every 110 match, and returns them over valid/ready.
// Build option: define SEQ110_HISTORY_CARRY_EN to keep detector history
// across words; otherwise history is cleared on every word accept.
module seq110_word_scheduler
  import seq110_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_pos,
  output logic              busy
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   pos_q, pos_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                core_clear, core_bit_en, core_bit, core_hit;

  seq110_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (core_clear),
    .bit_en (core_bit_en),
    .bit_in (core_bit),
    .hit    (core_hit)
  );

  // Next-state, datapath and detector control; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    count_d     = count_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    core_clear  = 1'b0;
    core_bit_en = 1'b0;
    core_bit    = data_q[idx_q];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          idx_d   = IDX_W'(WORD_W - 1);
          count_d = '0;
          pos_d   = '0;
          state_d = SHIFT;
`ifndef SEQ110_HISTORY_CARRY_EN
          core_clear = 1'b1;
`endif
        end
      end
      SHIFT: begin
        core_bit_en = 1'b1;
        if (core_hit) begin
          pos_d[idx_q] = 1'b1;
          count_d      = count_q + CNT_W'(1);
        end
        if (idx_q == '0) begin
          state_d     = REPORT;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      core_clear  = 1'b1;
    end
  end

  // in_ready is registered from the next state, so it never depends
  // combinationally on out_ready and is low for the cycle after reset.
  assign in_ready_d = (state_d == IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign out_pos   = pos_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq110_word_scheduler.sv
// Directed self-checking bench for seq110_word_scheduler (WORD_W=8, CNT_W=4).
// Expected values are hand-computed; the carry build changes one expectation.
module tb_seq110_word_scheduler;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_pos;
  logic              busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  seq110_word_scheduler #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_pos   (out_pos),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word once in_ready is seen, then count edges after the accept
  // edge until out_valid rises. Returns that edge count (0 on timeout).
  task automatic send_word(input string tag, input logic [WORD_W-1:0] w, output int unsigned lat);
    int unsigned n;
    logic ok;
    ok = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_rdy_wait"}, {31'd0, ok}, 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    chk({tag, "_acc_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_acc_inrdy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_word(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_ovalid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hs_inrdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_hs_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Full transaction with result check; the accept edge is cycle 0 and the
  // result appears WORD_W edges later, i.e. during cycle WORD_W+1.
  task automatic run_word(input string tag, input logic [WORD_W-1:0] w,
                          input logic [CNT_W-1:0] ecnt, input logic [WORD_W-1:0] epos);
    int unsigned lat;
    send_word(tag, w, lat);
    chk({tag, "_lat"}, lat, WORD_W);
    chk({tag, "_cnt"}, {28'd0, out_count}, {28'd0, ecnt});
    chk({tag, "_pos"}, {24'd0, out_pos}, {24'd0, epos});
    finish_word(tag);
  endtask

  initial begin
    int unsigned lat;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", {28'd0, out_count}, 32'd0);
    chk("rst_pos", {24'd0, out_pos}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_inrdy0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_inrdy1", {31'd0, in_ready}, 32'd1);

    // 1: basic word, two matches
    run_word("t1", 8'b0110_1100, 4'd2, 8'b0001_0010);

    // 2: history across words
    run_word("t2a", 8'b0000_0011, 4'd0, 8'b0000_0000);
`ifdef SEQ110_HISTORY_CARRY_EN
    run_word("t2b", 8'b0000_0000, 4'd1, 8'b1000_0000);
`else
    run_word("t2b", 8'b0000_0000, 4'd0, 8'b0000_0000);
`endif

    // 3: backpressure holds the result and blocks new words
    send_word("t3", 8'b0110_1100, lat);
    chk("t3_lat", lat, WORD_W);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFE;
      tick();
      in_valid = 1'b0;
      chk("t3_bp_ovalid", {31'd0, out_valid}, 32'd1);
      chk("t3_bp_cnt", {28'd0, out_count}, 32'd2);
      chk("t3_bp_pos", {24'd0, out_pos}, 32'h12);
      chk("t3_bp_inrdy", {31'd0, in_ready}, 32'd0);
    end
    finish_word("t3");

    // 4: flush on the 3rd SHIFT cycle drops the word
    in_valid = 1'b1;
    in_data  = 8'b0110_1100;
    tick();
    in_valid = 1'b0;
    chk("t4_acc_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_fl_busy", {31'd0, busy}, 32'd0);
    chk("t4_fl_inrdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < WORD_W + 2; i++) begin
      tick();
      chk("t4_fl_ovalid", {31'd0, out_valid}, 32'd0);
    end
    // flush in IDLE with in_valid high must not accept
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_fl_idle_busy", {31'd0, busy}, 32'd0);
    run_word("t4", 8'b1101_1011, 4'd2, 8'b0010_0100);

    // 5: reset during REPORT
    send_word("t5", 8'b0110_1100, lat);
    chk("t5_lat", lat, WORD_W);
    chk("t5_ovalid_pre", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_cnt", {28'd0, out_count}, 32'd0);
    tick();
    chk("t5_rst_inrdy_hold", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("t5_rel_inrdy0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t5_rel_inrdy1", {31'd0, in_ready}, 32'd1);
    chk("t5_rel_busy", {31'd0, busy}, 32'd0);

    // 6: all ones, and a single trailing match
    run_word("t6a", 8'hFF, 4'd0, 8'h00);
    run_word("t6b", 8'b1111_1110, 4'd1, 8'b0000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
